// File: rtl/fpga_cfg_loader.sv
// Bitstream loader for fpga_top's parallel configuration ports.
// Frame: sync byte, NBYTES payload bytes (LSB-first bit packing), 8-bit additive checksum.
// Payload is collected in a shadow register; live outputs copy it in one step on a good
// checksum, so fpga_top never sees a partial configuration.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: begin (or abort and restart) a load
//   in_valid/in_data  byte stream; in_ready = loader accepts this cycle
//   *select           live configuration vectors
//   cfg_busy          load in progress
//   cfg_done          sticky: last load committed
//   cfg_error         sticky: last load failed its checksum
module fpga_cfg_loader #(
  parameter int unsigned BRB_W = 750,
  parameter int unsigned BSB_W = 1728,
  parameter int unsigned LB_W  = 80,
  parameter int unsigned IO_W  = 30,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [BRB_W-1:0] brbselect,
  output logic [BSB_W-1:0] bsbselect,
  output logic [LB_W-1:0]  lbselect,
  output logic [IO_W-1:0]  leftioselect,
  output logic [IO_W-1:0]  rightioselect,
  output logic [IO_W-1:0]  topioselect,
  output logic [IO_W-1:0]  bottomioselect,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_error
);

  localparam int unsigned TOT_W  = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int unsigned NBYTES = (TOT_W + 7) / 8;
  localparam int unsigned SH_W   = NBYTES * 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(SH_W);

  localparam int unsigned BSB_LO = BRB_W;
  localparam int unsigned LB_LO  = BSB_LO + BSB_W;
  localparam int unsigned L_LO   = LB_LO + LB_W;
  localparam int unsigned R_LO   = L_LO + IO_W;
  localparam int unsigned T_LO   = R_LO + IO_W;
  localparam int unsigned B_LO   = T_LO + IO_W;

  localparam logic [CNT_W-1:0] LastByte = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StHunt, StLoad, StCheck} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [TOT_W-1:0]  live_q, live_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_pad;

  assign accept = in_valid & in_ready;
  assign wr_idx = IDX_W'(byte_cnt_q) << 3;
  // Pad bits of the last byte only feed the checksum, never the outputs.
  assign unused_pad = ^shadow_q[SH_W-1:SH_W-8];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start wins over a same-cycle byte
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StHunt;
    end else if (accept) begin
      case (state_q)
        StHunt:  if (in_data == SYNC) state_d = StLoad;
        StLoad:  if (byte_cnt_q == LastByte) state_d = StCheck;
        StCheck: state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    cfg_busy = (state_q != StIdle);
    in_ready = cfg_busy & ~start;
  end

  // Datapath next state
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    shadow_d   = shadow_q;
    live_d     = live_q;
    done_d     = done_q;
    error_d    = error_q;
    if (start) begin
      // Entering HUNT; stale shadow bytes are all overwritten before any commit.
      byte_cnt_d = '0;
      sum_d      = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end else if (accept) begin
      case (state_q)
        StLoad: begin
          shadow_d[wr_idx +: 8] = in_data;
          sum_d                 = sum_q + in_data;
          byte_cnt_d            = byte_cnt_q + CNT_W'(1);
        end
        StCheck: begin
          if (in_data == sum_q) begin
            live_d = shadow_q[TOT_W-1:0];
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      sum_q      <= '0;
      shadow_q   <= '0;
      live_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      shadow_q   <= shadow_d;
      live_q     <= live_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign brbselect      = live_q[BRB_W-1:0];
  assign bsbselect      = live_q[BSB_LO +: BSB_W];
  assign lbselect       = live_q[LB_LO +: LB_W];
  assign leftioselect   = live_q[L_LO +: IO_W];
  assign rightioselect  = live_q[R_LO +: IO_W];
  assign topioselect    = live_q[T_LO +: IO_W];
  assign bottomioselect = live_q[B_LO +: IO_W];
  assign cfg_done       = done_q;
  assign cfg_error      = error_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: frames are issued by the main process, which pushes
// the expected completion (done/error/config) into a queue; a monitor pops and compares each
// time the loader leaves its busy state.
module tb_fpga_cfg_loader;

  localparam int BRB_W  = 750;
  localparam int BSB_W  = 1728;
  localparam int LB_W   = 80;
  localparam int IO_W   = 30;
  localparam int TOT_W  = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NBYTES = (TOT_W + 7) / 8;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready;
  logic [7:0] in_data;
  logic [BRB_W-1:0] brbselect;
  logic [BSB_W-1:0] bsbselect;
  logic [LB_W-1:0]  lbselect;
  logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
  logic cfg_busy, cfg_done, cfg_error;

  always #5 clk = ~clk;

  fpga_cfg_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .brbselect     (brbselect),
    .bsbselect     (bsbselect),
    .lbselect      (lbselect),
    .leftioselect  (leftioselect),
    .rightioselect (rightioselect),
    .topioselect   (topioselect),
    .bottomioselect(bottomioselect),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error)
  );

  logic [TOT_W-1:0] dut_cfg;
  assign dut_cfg = {bottomioselect, topioselect, rightioselect, leftioselect,
                    lbselect, bsbselect, brbselect};

  typedef struct {
    logic             done;
    logic             err;
    logic [TOT_W-1:0] cfg;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  byte unsigned     pl[NBYTES];
  logic [TOT_W-1:0] model_live = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Payload bit k is byte k/8, bit k%8.
  function automatic logic [TOT_W-1:0] payload_bits();
    logic [TOT_W-1:0] r;
    for (int k = 0; k < TOT_W; k++) r[k] = pl[k/8][k%8];
    return r;
  endfunction

  function automatic logic [7:0] payload_sum();
    int s = 0;
    for (int i = 0; i < NBYTES; i++) s += pl[i];
    return 8'(s % 256);
  endfunction

  // Monitor: each busy->idle transition outside reset is one completed frame.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    int   first;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && prev_busy && !cfg_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: actual done=%b error=%b required none",
                   cfg_done, cfg_error);
        end else begin
          e = exp_q.pop_front();
          check("cfg_done", {31'b0, cfg_done}, {31'b0, e.done});
          check("cfg_error", {31'b0, cfg_error}, {31'b0, e.err});
          n_cmp++;
          if (dut_cfg !== e.cfg) begin
            n_bad++;
            first = -1;
            for (int k = TOT_W - 1; k >= 0; k--) if (dut_cfg[k] !== e.cfg[k]) first = k;
            $display("FAIL cfg: first differing bit %0d actual %b required %b (%0d ones vs %0d)",
                     first, dut_cfg[first], e.cfg[first], $countones(dut_cfg),
                     $countones(e.cfg));
          end
        end
      end
      prev_busy = cfg_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    if (max_gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(max_gap, 1)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // cs_sel: -1 correct checksum, -2 random wrong checksum, otherwise the literal byte.
  task automatic run_frame(input bit t2_lead, input int n_junk, input int max_gap,
                           input int cs_sel);
    exp_t       e;
    logic [7:0] b, sum, cs;
    pulse_start();
    if (t2_lead) begin
      send_byte(8'h00, max_gap);
      send_byte(8'h11, max_gap);
    end
    repeat (n_junk) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, max_gap);
    end
    send_byte(8'hA5, max_gap);
    for (int i = 0; i < NBYTES; i++) send_byte(pl[i], max_gap);
    sum = payload_sum();
    if (cs_sel == -1) cs = sum;
    else if (cs_sel == -2) cs = sum + 8'($urandom_range(255, 1));
    else cs = 8'(cs_sel);
    if (cs == sum) begin
      model_live = payload_bits();
      e.done = 1'b1;
      e.err  = 1'b0;
    end else begin
      e.done = 1'b0;
      e.err  = 1'b1;
    end
    e.cfg = model_live;
    exp_q.push_back(e);
    send_byte(cs, max_gap);
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: actual busy=%b required completed frame", cfg_busy);
      exp_q.delete();
    end
  endtask

  task automatic set_t2();
    for (int i = 0; i < NBYTES; i++) pl[i] = 8'h00;
    pl[0]          = 8'h05;
    pl[NBYTES - 1] = 8'h3F;
  endtask

  task automatic check_t2_fields(input string tag);
    @(negedge clk);
    check({tag, "_brb0"}, {31'b0, brbselect[0]}, 32'd1);
    check({tag, "_brb2"}, {31'b0, brbselect[2]}, 32'd1);
    check({tag, "_bottom_hi"}, {26'b0, bottomioselect[29:24]}, 32'h3F);
    check({tag, "_ones"}, $countones(dut_cfg), 32'd8);
    tick();
  endtask

  initial begin : main
    int rdy_seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // T1 reset
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {31'b0, cfg_busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_done", {31'b0, cfg_done}, 32'd0);
    check("rst_error", {31'b0, cfg_error}, 32'd0);
    check("rst_cfg_ones", $countones(dut_cfg), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Idle ignores bytes without start
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("idle_busy", {31'b0, cfg_busy}, 32'd0);

    // T2 good load
    set_t2();
    run_frame(1'b1, 0, 0, -1);
    check_t2_fields("t2");

    // T3 bad checksum keeps T2 outputs
    pl[0] = 8'hFF;
    run_frame(1'b1, 0, 0, 8'h45);
    check_t2_fields("t3");

    // T4 gaps
    set_t2();
    run_frame(1'b1, 0, 3, -1);
    check_t2_fields("t4");

    // Randomized frames, some preceded by an aborted partial load
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(2, 0) == 0) begin
        pulse_start();
        send_byte(8'hA5, 0);
        repeat ($urandom_range(NBYTES - 1, 1)) send_byte(8'($urandom), 0);
      end
      for (int i = 0; i < NBYTES; i++) pl[i] = 8'($urandom);
      run_frame(1'b0, $urandom_range(3, 0), $urandom_range(2, 0),
                ($urandom_range(3, 0) == 0) ? -2 : -1);
    end

    // T5 abort mid-load, then full T2 stream
    pulse_start();
    send_byte(8'hA5, 0);
    repeat (100) send_byte(8'hFF, 0);
    set_t2();
    run_frame(1'b1, 0, 0, -1);
    check_t2_fields("t5");

    // T6 reset after payload byte 200
    for (int i = 0; i < NBYTES; i++) pl[i] = 8'($urandom);
    pulse_start();
    send_byte(8'hA5, 0);
    for (int i = 0; i <= 200; i++) send_byte(pl[i], 0);
    rst_n      = 1'b0;
    model_live = '0;
    @(negedge clk);
    check("t6_busy", {31'b0, cfg_busy}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd0);
    check("t6_done", {31'b0, cfg_done}, 32'd0);
    check("t6_error", {31'b0, cfg_error}, 32'd0);
    check("t6_cfg_ones", $countones(dut_cfg), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    set_t2();
    rdy_seen = 0;
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'hA5, 0);
    for (int i = 0; i < NBYTES; i++) begin
      in_valid = 1'b1;
      in_data  = pl[i];
      if (in_ready) rdy_seen++;
      tick();
    end
    in_valid = 1'b1;
    in_data  = 8'h44;
    if (in_ready) rdy_seen++;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t6_ready_seen", rdy_seen, 32'd0);
    check("t6_after_busy", {31'b0, cfg_busy}, 32'd0);
    check("t6_after_done", {31'b0, cfg_done}, 32'd0);
    check("t6_after_ones", $countones(dut_cfg), 32'd0);

    check("pending_expectations", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
